// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: one inverse round per clock.
// Round keys are read by index from an external, already-expanded key store.
// The S-box inverse is computed arithmetically (inverse affine map followed
// by the GF(2^8) multiplicative inverse) instead of being held as a table.
module aes_decrypt_core #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  localparam logic [3:0] LAST_KEY  = 4'(NR);
  localparam logic [3:0] FIRST_RND = 4'(NR - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] pt_q, pt_d;
  logic         out_valid_q, out_valid_d;

  logic [127:0] sub_shift;
  logic [127:0] key_added;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Byte k sits at [127-8k -: 8]; row = k % 4, column = k / 4
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c - r + 4) % 4) + r;
        o[127 - 8 * (4 * c + r) -: 8] = inv_sbox(s[127 - 8 * src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Shared inverse-round datapath; FINAL simply skips the InvMixColumns stage
  always_comb begin
    sub_shift = inv_shift_sub(blk_q);
    key_added = sub_shift ^ rk_data;
    round_out = inv_mix_columns(key_added);
  end

  // Key index comes only from registered state so the key store path never loops back to the handshakes
  always_comb begin
    rk_idx = 4'd0;
    case (state_q)
      S_IDLE:  rk_idx = LAST_KEY;
      S_ROUND: rk_idx = cnt_q;
      default: rk_idx = 4'd0;
    endcase
  end

  // Next-state and datapath updates for the round sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    pt_d        = pt_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          blk_d   = ciphertext ^ rk_data;
          cnt_d   = FIRST_RND;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        blk_d = round_out;
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_FINAL;
      end
      S_FINAL: begin
        pt_d        = key_added;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = LAST_KEY;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset wins over any handshake in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= LAST_KEY;
      blk_q       <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: known-answer blocks, key-index sequencing,
// backpressure, back-to-back, reset abort and random encrypt/decrypt round trips.
// Expected plaintexts come from FIPS-197 vectors or from the bench's own
// forward AES cipher and key schedule, built from a brute-force S-box.
module tb_aes_decrypt_core;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  logic [127:0] rk_store [0:10];
  logic [7:0]   sbox [256];

  int checks;
  int failures;

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt_core #(.NR(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  assign rk_data = (rk_idx <= 4'd10) ? rk_store[rk_idx] : 128'd0;

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck design can never hang the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? (8'({a, 1'b0}) ^ 8'h1b) : 8'({a, 1'b0});
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk_store[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] encryptBlock(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = pt ^ rk_store[0];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox[v[127 - 8 * k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4 * c + rr] = s[4 * ((c + rr) % 4) + rr];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int rr = 0; rr < 4; rr++) s[4 * c + rr] = t[4 * c + rr];
        end
      end
      for (int k = 0; k < 16; k++) v[127 - 8 * k -: 8] = s[k];
      v = v ^ rk_store[r];
    end
    return v;
  endfunction

  task automatic waitReady(input string tag);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    checkOutput({tag, "_ready"}, 128'(in_ready), 128'd1);
  endtask

  // One full block with out_ready held high: latency, result, single-cycle pulse
  task automatic applyStimulus(input logic [127:0] ct, input logic [127:0] exp, input string tag);
    int lat;
    @(negedge clk);
    waitReady(tag);
    checkOutput({tag, "_rkidle"}, 128'(rk_idx), 128'd10);
    ciphertext = ct;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, 128'(lat), 128'd10);
    checkOutput({tag, "_pt"}, plaintext, exp);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 128'(out_valid), 128'd0);
    checkOutput({tag, "_idle"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    int lat;
    int w;
    logic seen;
    logic [127:0] key;
    logic [127:0] pt;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    ciphertext = '0;
    for (int r = 0; r <= 10; r++) rk_store[r] = '0;
    buildSbox();
    expandKey(KEY1);

    // Reset, with in_valid asserted to show reset has priority
    repeat (2) @(negedge clk);
    in_valid   = 1'b1;
    ciphertext = CT1;
    @(negedge clk);
    checkOutput("rst_busy", 128'(busy), 128'd0);
    checkOutput("rst_ready", 128'(in_ready), 128'd1);
    checkOutput("rst_outvalid", 128'(out_valid), 128'd0);
    checkOutput("rst_pt", plaintext, 128'd0);
    checkOutput("rst_rkidx", 128'(rk_idx), 128'd10);
    in_valid = 1'b0;
    rst      = 1'b0;

    // Known-answer test
    applyStimulus(CT1, PT1, "kat1");

    // Key-index sequence followed by backpressure in DONE
    @(negedge clk);
    waitReady("seq");
    out_ready  = 1'b0;
    ciphertext = CT1;
    in_valid   = 1'b1;
    checkOutput("seq_rk_accept", 128'(rk_idx), 128'd10);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 9; i >= 1; i--) begin
      checkOutput("seq_rk_round", 128'(rk_idx), 128'(i));
      @(negedge clk);
    end
    checkOutput("seq_rk_final", 128'(rk_idx), 128'd0);
    checkOutput("seq_final_novalid", 128'(out_valid), 128'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", 128'(out_valid), 128'd1);
      checkOutput("bp_pt", plaintext, PT1);
      checkOutput("bp_ready", 128'(in_ready), 128'd0);
      checkOutput("bp_rk_done", 128'(rk_idx), 128'd0);
      in_valid   = (i == 2);
      ciphertext = CT2;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_hs_valid", 128'(out_valid), 128'd0);
    checkOutput("bp_hs_ready", 128'(in_ready), 128'd1);
    checkOutput("bp_hs_rk", 128'(rk_idx), 128'd10);
    @(negedge clk);
    checkOutput("bp_stay_idle", 128'(busy), 128'd0);

    // Back-to-back blocks with in_valid held high, key store swapped while DONE
    waitReady("b2b");
    ciphertext = CT1;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("b2b_lat1", 128'(lat), 128'd10);
    checkOutput("b2b_pt1", plaintext, PT1);
    expandKey(KEY2);
    ciphertext = CT2;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    checkOutput("b2b_lat2", 128'(lat), 128'd12);
    checkOutput("b2b_pt2", plaintext, PT2);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_pulse", 128'(out_valid), 128'd0);

    // Reset while the round counter is at 5
    expandKey(KEY1);
    waitReady("abort");
    ciphertext = CT1;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (rk_idx != 4'd5 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput("abort_cnt5", 128'(rk_idx), 128'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_valid", 128'(out_valid), 128'd0);
    checkOutput("abort_busy", 128'(busy), 128'd0);
    checkOutput("abort_ready", 128'(in_ready), 128'd1);
    checkOutput("abort_pt", plaintext, 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    checkOutput("abort_nopartial", 128'(seen), 128'd0);
    applyStimulus(CT1, PT1, "after_abort");

    // Random round trips through the bench's forward cipher
    for (int i = 0; i < 100; i++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expandKey(key);
      applyStimulus(encryptBlock(pt), pt, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
